// File: rtl/st_irq_ctrl.sv
// st_irq_ctrl: interrupt controller between the ST interrupt sources
// (HBL, VBL, MFP) and the 68000. It encodes pending requests onto the IPL
// lines and runs each CPU interrupt-acknowledge cycle. Level 6 goes to the
// MFP vectored iack/dtack handshake. Levels 2 and 4 are answered by
// autovector (VPA). Anything else, or an MFP that never answers, gets BERR.
// All state advances only on clk_en ticks. Reset is synchronous and
// overrides clk_en.
module st_irq_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       hbl_in,
    input  logic       vbl_in,
    input  logic       mfp_irq,
    input  logic       mfp_dtack,
    input  logic [2:0] cpu_fc,
    input  logic [2:0] cpu_a,
    input  logic       cpu_as_n,
    output logic [2:0] ipl_n,
    output logic       mfp_iack,
    output logic       vpa,
    output logic       berr,
    output logic       busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_MFP_WAIT = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t        state_r;
    logic [2:0]    lvl_r;
    logic [CW-1:0] cnt_r;
    logic          hbl_prev_r;
    logic          vbl_prev_r;
    logic          hbl_pend_r;
    logic          vbl_pend_r;
    logic [2:0]    ipl_n_r;
    logic          mfp_iack_r;
    logic          vpa_r;
    logic          berr_r;
    logic          busy_r;

    logic          hbl_rise_s;
    logic          vbl_rise_s;
    logic          iack_s;
    logic          hbl_clr_s;
    logic          vbl_clr_s;

    // Highest active source wins: MFP (6) over VBL (4) over HBL (2).
    function automatic logic [2:0] encode_level(input logic mfp,
                                                input logic vbl,
                                                input logic hbl);
        logic [2:0] lvl;
        if (mfp) begin
            lvl = 3'd6;
        end else if (vbl) begin
            lvl = 3'd4;
        end else if (hbl) begin
            lvl = 3'd2;
        end else begin
            lvl = 3'd0;
        end
        return lvl;
    endfunction

    // Source edges, iack detection and pending-clear requests from the
    // cycle being dispatched.
    always_comb begin
        hbl_rise_s = 1'b0;
        vbl_rise_s = 1'b0;
        iack_s     = 1'b0;
        hbl_clr_s  = 1'b0;
        vbl_clr_s  = 1'b0;
        if (hbl_in && !hbl_prev_r) begin
            hbl_rise_s = 1'b1;
        end else begin
            hbl_rise_s = 1'b0;
        end
        if (vbl_in && !vbl_prev_r) begin
            vbl_rise_s = 1'b1;
        end else begin
            vbl_rise_s = 1'b0;
        end
        if ((cpu_fc == 3'b111) && !cpu_as_n) begin
            iack_s = 1'b1;
        end else begin
            iack_s = 1'b0;
        end
        // An aborted dispatch (strobe already released) clears nothing.
        if ((state_r == ST_DISPATCH) && !cpu_as_n) begin
            hbl_clr_s = (lvl_r == 3'd2);
            vbl_clr_s = (lvl_r == 3'd4);
        end else begin
            hbl_clr_s = 1'b0;
            vbl_clr_s = 1'b0;
        end
    end

    // Edge-detect delay registers and pending bits. A new edge beats a
    // clear in the same tick so it is not lost during its own ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            hbl_prev_r <= 1'b0;
            vbl_prev_r <= 1'b0;
            hbl_pend_r <= 1'b0;
            vbl_pend_r <= 1'b0;
        end else if (clk_en) begin
            hbl_prev_r <= hbl_in;
            vbl_prev_r <= vbl_in;
            hbl_pend_r <= hbl_rise_s | (hbl_pend_r & ~hbl_clr_s);
            vbl_pend_r <= vbl_rise_s | (vbl_pend_r & ~vbl_clr_s);
        end else begin
            hbl_prev_r <= hbl_prev_r;
            vbl_prev_r <= vbl_prev_r;
            hbl_pend_r <= hbl_pend_r;
            vbl_pend_r <= vbl_pend_r;
        end
    end

    // Registered active-low priority level towards the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            ipl_n_r <= 3'b111;
        end else if (clk_en) begin
            ipl_n_r <= ~encode_level(mfp_irq, vbl_pend_r, hbl_pend_r);
        end else begin
            ipl_n_r <= ipl_n_r;
        end
    end

    // Interrupt-acknowledge sequencer. It drives at most one of
    // mfp_iack / vpa / berr at any time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lvl_r      <= 3'd0;
            cnt_r      <= '0;
            mfp_iack_r <= 1'b0;
            vpa_r      <= 1'b0;
            berr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else if (clk_en) begin
            case (state_r)
                ST_IDLE: begin
                    mfp_iack_r <= 1'b0;
                    vpa_r      <= 1'b0;
                    berr_r     <= 1'b0;
                    if (iack_s) begin
                        lvl_r   <= cpu_a;
                        state_r <= ST_DISPATCH;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_DISPATCH: begin
                    if (cpu_as_n) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        case (lvl_r)
                            3'd6: begin
                                mfp_iack_r <= 1'b1;
                                cnt_r      <= '0;
                                state_r    <= ST_MFP_WAIT;
                            end
                            3'd4, 3'd2: begin
                                vpa_r   <= 1'b1;
                                state_r <= ST_HOLD;
                            end
                            default: begin
                                berr_r  <= 1'b1;
                                state_r <= ST_HOLD;
                            end
                        endcase
                    end
                end
                ST_MFP_WAIT: begin
                    if (cpu_as_n) begin
                        mfp_iack_r <= 1'b0;
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end else if (mfp_dtack) begin
                        state_r <= ST_HOLD;
                    end else if (cnt_r == CNT_LAST) begin
                        mfp_iack_r <= 1'b0;
                        berr_r     <= 1'b1;
                        state_r    <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cpu_as_n) begin
                        mfp_iack_r <= 1'b0;
                        vpa_r      <= 1'b0;
                        berr_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    mfp_iack_r <= 1'b0;
                    vpa_r      <= 1'b0;
                    berr_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign ipl_n    = ipl_n_r;
    assign mfp_iack = mfp_iack_r;
    assign vpa      = vpa_r;
    assign berr     = berr_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_st_irq_ctrl.sv
// Directed bench for st_irq_ctrl with TIMEOUT=8. clk_en is pulsed once
// every two clocks by the tick task, so the idle clock in between also
// shows that nothing advances without clk_en.
module tb_st_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b0;
    logic       hbl_in = 1'b0;
    logic       vbl_in = 1'b0;
    logic       mfp_irq = 1'b0;
    logic       mfp_dtack = 1'b0;
    logic [2:0] cpu_fc = 3'b000;
    logic [2:0] cpu_a = 3'b000;
    logic       cpu_as_n = 1'b1;
    logic [2:0] ipl_n;
    logic       mfp_iack;
    logic       vpa;
    logic       berr;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;

    st_irq_ctrl #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .hbl_in    (hbl_in),
        .vbl_in    (vbl_in),
        .mfp_irq   (mfp_irq),
        .mfp_dtack (mfp_dtack),
        .cpu_fc    (cpu_fc),
        .cpu_a     (cpu_a),
        .cpu_as_n  (cpu_as_n),
        .ipl_n     (ipl_n),
        .mfp_iack  (mfp_iack),
        .vpa       (vpa),
        .berr      (berr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // strobes packed as {mfp_iack, vpa, berr, busy}
    task automatic check_strobes(input string tag, input logic [3:0] exp);
        check(tag, {mfp_iack, vpa, berr, busy}, exp);
    endtask

    task automatic start_iack(input logic [2:0] lvl);
        cpu_fc   = 3'b111;
        cpu_a    = lvl;
        cpu_as_n = 1'b0;
    endtask

    task automatic end_iack();
        cpu_fc   = 3'b000;
        cpu_as_n = 1'b1;
    endtask

    initial begin
        // Reset with every source active and an iack on the bus
        reset = 1'b1; hbl_in = 1'b1; vbl_in = 1'b1; mfp_irq = 1'b1;
        start_iack(3'd6);
        tick(); tick();
        check("reset_ipl", {1'b0, ipl_n}, 4'b0111);
        check_strobes("reset_strobes", 4'b0000);
        hbl_in = 1'b0; vbl_in = 1'b0; mfp_irq = 1'b0;
        end_iack();
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("idle_ipl", {1'b0, ipl_n}, 4'b0111);
        check_strobes("idle_strobes", 4'b0000);

        // Priority: MFP over VBL
        vbl_in = 1'b1; mfp_irq = 1'b1;
        tick();
        check("prio_mfp", {1'b0, ipl_n}, 4'b0001);
        vbl_in = 1'b0; mfp_irq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("gate_hold", {1'b0, ipl_n}, 4'b0001);
        tick();
        check("prio_vbl", {1'b0, ipl_n}, 4'b0011);

        // Autovector ack of level 4
        start_iack(3'd4);
        tick();
        check_strobes("av_dispatch", 4'b0001);
        tick();
        check_strobes("av_vpa", 4'b0101);
        check("av_ipl_hold", {1'b0, ipl_n}, 4'b0011);
        tick();
        check("av_ipl_clr", {1'b0, ipl_n}, 4'b0111);
        check_strobes("av_hold", 4'b0101);
        end_iack();
        tick();
        check_strobes("av_release", 4'b0000);

        // MFP vectored ack, dtack after 5 wait ticks
        mfp_irq = 1'b1;
        tick();
        check("mfp_ipl", {1'b0, ipl_n}, 4'b0001);
        start_iack(3'd6);
        tick();
        check_strobes("mfp_dispatch", 4'b0001);
        tick();
        check_strobes("mfp_iack_on", 4'b1001);
        repeat (5) tick();
        check_strobes("mfp_waiting", 4'b1001);
        mfp_dtack = 1'b1;
        tick();
        mfp_dtack = 1'b0;
        check_strobes("mfp_dtack", 4'b1001);
        tick();
        check_strobes("mfp_hold", 4'b1001);
        end_iack();
        tick();
        check_strobes("mfp_release", 4'b0000);

        // MFP timeout: berr on the 8th wait tick
        start_iack(3'd6);
        tick(); tick();
        repeat (7) tick();
        check_strobes("to_tick7", 4'b1001);
        tick();
        check_strobes("to_berr", 4'b0011);
        tick();
        check_strobes("to_hold", 4'b0011);
        end_iack();
        tick();
        check_strobes("to_release", 4'b0000);
        mfp_irq = 1'b0;

        // HBL ack with a new HBL edge landing on the clearing tick
        hbl_in = 1'b1; tick();
        hbl_in = 1'b0; tick();
        check("hbl_ipl", {1'b0, ipl_n}, 4'b0101);
        start_iack(3'd2);
        tick();
        hbl_in = 1'b1;
        tick();
        hbl_in = 1'b0;
        check_strobes("race_vpa", 4'b0101);
        tick();
        end_iack();
        tick();
        check_strobes("race_release", 4'b0000);
        tick();
        check("race_pend_kept", {1'b0, ipl_n}, 4'b0101);

        // Plain HBL ack clears it
        start_iack(3'd2);
        tick(); tick(); tick();
        end_iack();
        tick(); tick();
        check("hbl_cleared", {1'b0, ipl_n}, 4'b0111);

        // Spurious level 5
        start_iack(3'd5);
        tick(); tick();
        check_strobes("spur_berr", 4'b0011);
        end_iack();
        tick();
        check_strobes("spur_release", 4'b0000);

        // Abort during MFP wait leaves VBL pending untouched
        vbl_in = 1'b1; tick();
        vbl_in = 1'b0; tick();
        start_iack(3'd6);
        tick(); tick();
        check_strobes("abort_wait", 4'b1001);
        end_iack();
        tick();
        check_strobes("abort_idle", 4'b0000);
        check("abort_ipl", {1'b0, ipl_n}, 4'b0011);

        // Reset mid-cycle wins without clk_en
        start_iack(3'd6);
        tick(); tick();
        check_strobes("pre_reset", 4'b1001);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_strobes("midreset_strobes", 4'b0000);
        check("midreset_ipl", {1'b0, ipl_n}, 4'b0111);
        reset = 1'b0;
        end_iack();
        tick();
        check_strobes("after_reset", 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
